// File: rtl/stream_arb_2to1.sv
// Two-input round-robin stream arbiter with packet-granular locking.
// Drives the 2:1 mux select and registers the winning beat.
module stream_arb_2to1 #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [DATA_W-1:0] a_data,
   input  logic              a_last,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [DATA_W-1:0] b_data,
   input  logic              b_last,
   output logic              b_ready,
   output logic              y_valid,
   output logic [DATA_W-1:0] y_data,
   output logic              y_last,
   output logic              y_sel,
   input  logic              y_ready
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCK_A = 2'd1,
      ST_LOCK_B = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_prio;
   logic              w_prio_nxt;
   logic              r_y_valid;
   logic [DATA_W-1:0] r_y_data;
   logic              r_y_last;
   logic              r_y_sel;

   logic w_load_en;
   logic w_grant_a;
   logic w_grant_b;
   logic w_acc_a;
   logic w_acc_b;

   assign w_load_en = !r_y_valid || y_ready;

   always_comb begin
      w_grant_a   = 1'b0;
      w_grant_b   = 1'b0;
      w_acc_a     = 1'b0;
      w_acc_b     = 1'b0;
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;

      case (r_state)
         ST_IDLE: begin
            if (a_valid && (!b_valid || !r_prio))
               w_grant_a = 1'b1;
            else if (b_valid)
               w_grant_b = 1'b1;
         end
         ST_LOCK_A: w_grant_a = 1'b1;
         ST_LOCK_B: w_grant_b = 1'b1;
         default: ;
      endcase

      w_acc_a = w_load_en && w_grant_a && a_valid;
      w_acc_b = w_load_en && w_grant_b && b_valid;

      // prio only moves when a packet completes
      if (w_acc_a) begin
         if (a_last) begin
            w_state_nxt = ST_IDLE;
            w_prio_nxt  = 1'b1;
         end else begin
            w_state_nxt = ST_LOCK_A;
         end
      end else if (w_acc_b) begin
         if (b_last) begin
            w_state_nxt = ST_IDLE;
            w_prio_nxt  = 1'b0;
         end else begin
            w_state_nxt = ST_LOCK_B;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_prio  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prio  <= w_prio_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_y_valid <= 1'b0;
         r_y_data  <= '0;
         r_y_last  <= 1'b0;
         r_y_sel   <= 1'b0;
      end else if (w_load_en) begin
         if (w_acc_a) begin
            r_y_valid <= 1'b1;
            r_y_data  <= a_data;
            r_y_last  <= a_last;
            r_y_sel   <= 1'b0;
         end else if (w_acc_b) begin
            r_y_valid <= 1'b1;
            r_y_data  <= b_data;
            r_y_last  <= b_last;
            r_y_sel   <= 1'b1;
         end else begin
            r_y_valid <= 1'b0;
         end
      end
   end

   assign a_ready = !rst && w_load_en && w_grant_a;
   assign b_ready = !rst && w_load_en && w_grant_b;

   assign y_valid = r_y_valid;
   assign y_data  = r_y_data;
   assign y_last  = r_y_last;
   assign y_sel   = r_y_sel;

endmodule
